// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, reset PC and word-address width.
// The FETCH_SKID_EN build option (see fetch_stage) uses the HOLD state and fetch_pkt_t.
package mips_pkg;

    localparam int WORD_ADDR_W = 30;

    // Word address [31:2] of the first fetch after reset (byte address 0x00003000)
    localparam logic [WORD_ADDR_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } fetch_state_e;

    // Instruction plus its PC+4 word address, as parked in the skid buffer
    typedef struct packed {
        logic [31:0]            instr;
        logic [WORD_ADDR_W-1:0] pc4;
    } fetch_pkt_t;

    // Next sequential word address; wraps from all-ones to zero
    function automatic logic [WORD_ADDR_W-1:0] pc_inc(input logic [WORD_ADDR_W-1:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a response that arrives while decode is stalled.
// Only instantiated when FETCH_SKID_EN is defined. Clear has priority over load.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  fetch_pkt_t din,
    output fetch_pkt_t dout,
    output logic       full
);

    fetch_pkt_t data_r;
    logic       full_r;

    // Capture a stalled response, release it on clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r <= '0;
            full_r <= 1'b0;
        end else if (clear) begin
            data_r <= '0;
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= din;
            full_r <= 1'b1;
        end
    end

    assign dout = data_r;
    assign full = full_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, keeps a single request outstanding to instruction
// memory, applies branch/jump redirects and presents instr/pc4 with a valid strobe
// to the IF/ID register. Define FETCH_SKID_EN to add a one-entry skid buffer so a
// response arriving under stall_f is parked (HOLD) instead of re-fetched.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_f,
    input  logic                   branch_taken,
    input  logic [WORD_ADDR_W-1:0] branch_target,
    input  logic                   jump_en,
    input  logic [WORD_ADDR_W-1:0] jump_target,
    output logic                   imem_req,
    output logic [WORD_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            instr_f,
    output logic [WORD_ADDR_W-1:0] pc4_f,
    output logic                   valid_f
);

    fetch_state_e           state_r;
    logic [WORD_ADDR_W-1:0] pc_r;
    logic                   drop_r;

    logic                   redirect_s;
    logic [WORD_ADDR_W-1:0] target_s;
    logic                   req_s;
    logic                   accept_s;
    logic                   resp_s;
    logic                   deliver_s;
    logic                   release_s;

`ifdef FETCH_SKID_EN
    logic       capture_s;
    logic       buf_clear_s;
    logic       buf_full_s;
    fetch_pkt_t buf_in_s;
    fetch_pkt_t buf_out_s;
`endif

    // Decode redirect, memory handshake and delivery conditions for this cycle
    always_comb begin
        redirect_s = branch_taken | jump_en;
        if (branch_taken) begin
            target_s = branch_target;
        end else begin
            target_s = jump_target;
        end
        if (rst_n && (state_r == REQ)) begin
`ifdef FETCH_SKID_EN
            req_s = 1'b1;
`else
            req_s = ~stall_f;
`endif
        end else begin
            req_s = 1'b0;
        end
        accept_s  = req_s & imem_ready;
        resp_s    = rst_n & (state_r == WAIT) & imem_rvalid;
        deliver_s = resp_s & ~drop_r & ~stall_f & ~redirect_s;
`ifdef FETCH_SKID_EN
        capture_s   = resp_s & ~drop_r & stall_f & ~redirect_s;
        release_s   = rst_n & (state_r == HOLD) & buf_full_s & ~stall_f & ~redirect_s;
        buf_clear_s = rst_n & (state_r == HOLD) & (redirect_s | ~stall_f);
`else
        release_s = 1'b0;
`endif
    end

    // Fetch FSM: PC, outstanding-request tracking and discard-on-redirect flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            drop_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= REQ;
                    if (redirect_s) pc_r <= target_s;
                end
                REQ: begin
                    if (redirect_s) pc_r <= target_s;
                    // A request accepted alongside a redirect fetched the old PC
                    if (accept_s) begin
                        state_r <= WAIT;
                        drop_r  <= redirect_s;
                    end
                end
                WAIT: begin
                    if (resp_s) begin
                        drop_r <= 1'b0;
                        if (redirect_s) begin
                            pc_r    <= target_s;
                            state_r <= REQ;
                        end else if (drop_r) begin
                            state_r <= REQ;
                        end else if (stall_f) begin
`ifdef FETCH_SKID_EN
                            state_r <= HOLD;
`else
                            state_r <= REQ;
`endif
                        end else begin
                            pc_r    <= pc_inc(pc_r);
                            state_r <= REQ;
                        end
                    end else if (redirect_s) begin
                        pc_r   <= target_s;
                        drop_r <= 1'b1;
                    end
                end
                HOLD: begin
`ifdef FETCH_SKID_EN
                    if (redirect_s) begin
                        pc_r    <= target_s;
                        state_r <= REQ;
                    end else if (!stall_f) begin
                        pc_r    <= pc_inc(pc_r);
                        state_r <= REQ;
                    end
`else
                    state_r <= REQ;
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_SKID_EN
    assign buf_in_s = '{instr: imem_rdata, pc4: pc_inc(pc_r)};

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (capture_s),
        .clear (buf_clear_s),
        .din   (buf_in_s),
        .dout  (buf_out_s),
        .full  (buf_full_s)
    );
`endif

    // Steer the delivered instruction from the memory response or the skid buffer
    always_comb begin
        valid_f = deliver_s | release_s;
        if (deliver_s) begin
            instr_f = imem_rdata;
            pc4_f   = pc_inc(pc_r);
        end
`ifdef FETCH_SKID_EN
        else if (release_s) begin
            instr_f = buf_out_s.instr;
            pc4_f   = buf_out_s.pc4;
        end
`endif
        else begin
            instr_f = 32'h0;
            pc4_f   = 30'h0;
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations followed by
// randomized stimulus checked every cycle against a transaction-level model.
module tb_fetch_stage;

`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall_f, branch_taken, jump_en;
    logic [29:0] branch_target, jump_target;
    logic        imem_req, imem_ready, imem_rvalid, valid_f;
    logic [29:0] imem_addr, pc4_f;
    logic [31:0] imem_rdata, instr_f;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_f(instr_f), .pc4_f(pc4_f), .valid_f(valid_f)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // model: architectural PC plus bookkeeping of the outstanding transaction
    logic [29:0] m_pc;
    bit          m_boot, m_busy, m_stale, m_held;
    logic [31:0] m_bi;
    logic [29:0] m_bp;

    // memory responder
    bit          mem_pend;
    int          mem_left;
    logic [29:0] mem_a;
    int          lat;
    bit          rnd_lat;

    // per-cycle samples and logs
    bit          s_req, s_valid, s_acc;
    logic [29:0] s_addr, s_pc4;
    logic [31:0] s_instr;
    logic [29:0] acc_q[$];
    logic [29:0] del_q[$];
    int          del_cyc[$];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [29:0] pick_target();
        logic [29:0] t;
        t = 30'($urandom);
        if ($urandom_range(0, 3) == 0) t = 30'h3FFF_FFFF - 30'($urandom_range(0, 2));
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [29:0] exp);
        if (idx < acc_q.size()) chk(name, {2'b00, acc_q[idx]}, {2'b00, exp});
        else begin
            n_cmp++; n_bad++;
            $display("FAIL %s: request %0d never accepted, expected address %h", name, idx, exp);
        end
    endtask

    task automatic chk_del(input string name, input int idx, input logic [29:0] exp);
        if (idx < del_q.size()) chk(name, {2'b00, del_q[idx]}, {2'b00, exp});
        else begin
            n_cmp++; n_bad++;
            $display("FAIL %s: delivery %0d never seen, expected pc4 %h", name, idx, exp);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete(); del_q.delete(); del_cyc.delete();
    endtask

    // One clock: sample and compare at negedge, advance model, then drive memory
    task automatic step();
        bit          redir, e_req, e_valid, resp;
        logic [29:0] tgt, e_pc4, n_pc;
        logic [31:0] e_instr;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = valid_f;
        s_pc4 = pc4_f; s_instr = instr_f;
        s_acc = imem_req && imem_ready;
        if (s_acc) acc_q.push_back(imem_addr);
        if (valid_f) begin del_q.push_back(pc4_f); del_cyc.push_back(cyc); end
        redir = branch_taken || jump_en;
        tgt   = branch_taken ? branch_target : jump_target;
        if (!rst_n) begin
            chk("req_in_reset", {31'd0, imem_req}, 32'd0);
            chk("valid_in_reset", {31'd0, valid_f}, 32'd0);
            m_pc = 30'h0000_0C00; m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        end else begin
            e_req = !m_boot && !m_busy && !m_held && (SKID || !stall_f);
            resp  = m_busy && imem_rvalid;
            if (m_held) begin
                e_valid = !stall_f && !redir; e_instr = m_bi; e_pc4 = m_bp;
            end else begin
                e_valid = resp && !m_stale && !stall_f && !redir;
                e_instr = imem_rdata; e_pc4 = m_pc + 30'd1;
            end
            chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) chk("imem_addr", {2'b00, imem_addr}, {2'b00, m_pc});
            chk("valid_f", {31'd0, valid_f}, {31'd0, e_valid});
            if (e_valid) begin
                chk("pc4_f", {2'b00, pc4_f}, {2'b00, e_pc4});
                chk("instr_f", instr_f, e_instr);
                chk("instr_vs_mem", instr_f, mem_word(e_pc4 - 30'd1));
            end
            n_pc = m_pc;
            if (redir) n_pc = tgt;
            else if (e_valid) n_pc = m_pc + 30'd1;
            if (m_held && (redir || !stall_f)) m_held = 1'b0;
            if (resp) begin
                if (SKID && !m_stale && stall_f && !redir) begin
                    m_held = 1'b1; m_bi = imem_rdata; m_bp = m_pc + 30'd1;
                end
                m_busy = 1'b0; m_stale = 1'b0;
            end else if (m_busy && redir) begin
                m_stale = 1'b1;
            end
            if (e_req && imem_ready) begin m_busy = 1'b1; m_stale = redir; end
            m_boot = 1'b0;
            m_pc   = n_pc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_pend) begin
            if (mem_left <= 1) mem_pend = 1'b0;
            else mem_left--;
        end
        if (s_acc) begin
            mem_pend = 1'b1;
            mem_left = rnd_lat ? int'($urandom_range(1, 3)) : lat;
            mem_a    = s_addr;
        end
        imem_rvalid = mem_pend && (mem_left == 1);
        imem_rdata  = imem_rvalid ? mem_word(mem_a) : $urandom;
    endtask

    // Step until the model is ready to issue (kind 0) or waiting with no response (kind 1)
    task automatic wait_model(input int kind, input string name);
        int n;
        n = 0;
        while (n < 40 && !((kind == 0) ? (!m_boot && !m_busy && !m_held)
                                       : (m_busy && !imem_rvalid))) begin
            step();
            n++;
        end
        if (n >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: model condition not reached within 40 cycles", name);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
        branch_target = 30'h0; jump_target = 30'h0; imem_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        mem_pend = 1'b0; mem_left = 0; mem_a = 30'h0; lat = 1; rnd_lat = 1'b0;
        m_pc = 30'h0000_0C00; m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        m_bi = 32'h0; m_bp = 30'h0;

        // reset state
        step(); step();
        chk("rst_req", {31'd0, s_req}, 32'd0);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_instr", s_instr, 32'd0);
        chk("rst_pc4", {2'b00, s_pc4}, 32'd0);

        // 1: zero-wait memory streams from RESET_PC, one instruction every 2 cycles
        rst_n = 1'b1;
        clear_logs();
        step();
        chk("idle_no_req", {31'd0, s_req}, 32'd0);
        repeat (7) step();
        chk_acc("t1_first_addr", 0, 30'h0000_0C00);
        chk_del("t1_pc4_0", 0, 30'h0000_0C01);
        chk_del("t1_pc4_1", 1, 30'h0000_0C02);
        chk_del("t1_pc4_2", 2, 30'h0000_0C03);
        if (del_cyc.size() >= 3) begin
            chk("t1_spacing_a", del_cyc[1] - del_cyc[0], 32'd2);
            chk("t1_spacing_b", del_cyc[2] - del_cyc[1], 32'd2);
        end

        // 2: branch while waiting drops the in-flight response
        lat = 2;
        wait_model(1, "t2_reach_wait");
        clear_logs();
        branch_taken = 1'b1; branch_target = 30'h0000_2000;
        step();
        branch_taken = 1'b0;
        step();
        chk("t2_dropped", {31'd0, s_valid}, 32'd0);
        repeat (6) step();
        chk_acc("t2_new_addr", 0, 30'h0000_2000);
        chk_del("t2_new_pc4", 0, 30'h0000_2001);

        // 3+5: branch beats jump; request held stable while memory not ready
        lat = 1; imem_ready = 1'b0;
        wait_model(0, "t3_reach_req");
        branch_taken = 1'b1; jump_en = 1'b1;
        branch_target = 30'h0000_0100; jump_target = 30'h0000_0200;
        step();
        branch_taken = 1'b0; jump_en = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_req_held", {31'd0, s_req}, 32'd1);
            chk("t5_addr_held", {2'b00, s_addr}, 32'h0000_0100);
            chk("t5_no_valid", {31'd0, s_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        repeat (4) step();
        chk_acc("t3_prio_addr", 0, 30'h0000_0100);
        chk_del("t3_prio_pc4", 0, 30'h0000_0101);

        // 6: PC wraps from all-ones to zero
        imem_ready = 1'b0;
        wait_model(0, "t6_reach_req");
        jump_en = 1'b1; jump_target = 30'h3FFF_FFFF;
        step();
        jump_en = 1'b0; imem_ready = 1'b1;
        clear_logs();
        repeat (6) step();
        chk_acc("t6_top_addr", 0, 30'h3FFF_FFFF);
        chk_del("t6_wrap_pc4", 0, 30'h0000_0000);
        chk_acc("t6_wrap_addr", 1, 30'h0000_0000);

        // 4: stall held 3 cycles across the response
        imem_ready = 1'b0;
        wait_model(0, "t4_reach_req");
        jump_en = 1'b1; jump_target = 30'h0000_0ABC;
        step();
        jump_en = 1'b0; imem_ready = 1'b1; lat = 2;
        step();
        clear_logs();
        stall_f = 1'b1;
        repeat (3) step();
        chk("t4_no_valid_in_stall", del_q.size(), 32'd0);
        stall_f = 1'b0;
        step();
        if (SKID) begin
            chk("t4_skid_valid", {31'd0, s_valid}, 32'd1);
            chk("t4_skid_pc4", {2'b00, s_pc4}, 32'h0000_0ABD);
            chk("t4_skid_instr", s_instr, mem_word(30'h0000_0ABC));
            repeat (5) step();
            chk_acc("t4_skid_next_addr", 0, 30'h0000_0ABD);
        end else begin
            chk("t4_replay_req", {31'd0, s_req}, 32'd1);
            chk("t4_replay_addr", {2'b00, s_addr}, 32'h0000_0ABC);
            repeat (5) step();
            chk_acc("t4_replay_acc", 0, 30'h0000_0ABC);
            chk_del("t4_replay_pc4", 0, 30'h0000_0ABD);
        end

        // randomized traffic, stalls, redirects and occasional resets
        rnd_lat = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            stall_f       = ($urandom_range(0, 3) == 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            jump_en       = ($urandom_range(0, 11) == 0);
            branch_target = pick_target();
            jump_target   = pick_target();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
